// File: rtl/sprite_layer_fetch.sv
// Sprite layer fetch: per requested pixel, test four sprite layers and
// stream one beat per layer (layer 0 first), TRANSPARENT where no cover.
module sprite_layer_fetch #(
  parameter int          SPRITE_W    = 20,
  parameter int          SPRITE_H    = 20,
  parameter int          ADDR_W      = 16,
  parameter logic [23:0] TRANSPARENT = 24'd17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_layer,
  input  logic              cfg_en,
  input  logic [4:0]        cfg_id,
  input  logic [9:0]        cfg_x,
  input  logic [9:0]        cfg_y,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_data,
  output logic              out_valid,
  output logic [4:0]        sprite_layer,
  output logic [4:0]        sprite_id,
  output logic [23:0]       data,
  output logic              pixel_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_LAST
  } state_t;

  state_t r_state;
  logic [1:0] r_k;

  logic [3:0]       r_en;
  logic [3:0][4:0]  r_id;
  logic [3:0][9:0]  r_x;
  logic [3:0][9:0]  r_y;

  logic [3:0]       s_en;
  logic [3:0][4:0]  s_id;
  logic [3:0][9:0]  s_x;
  logic [3:0][9:0]  s_y;
  logic [9:0]       r_px;
  logic [9:0]       r_py;

  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ehit;
  logic [4:0]        r_eid;
  logic              r_valid;
  logic [1:0]        r_layer;
  logic [4:0]        r_sid;
  logic [23:0]       r_data;
  logic              r_bhit;
  logic              r_done;

  logic [1:0]        w_l;
  logic              w_en;
  logic [4:0]        w_id;
  logic [9:0]        w_x;
  logic [9:0]        w_y;
  logic [9:0]        w_px;
  logic [9:0]        w_py;
  logic              w_hit;
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic [ADDR_W-1:0] w_addr;

  // layer 0 is evaluated at accept from live state, later layers from the snapshot
  always_comb begin
    w_l  = (r_state == S_IDLE) ? 2'd0 : r_k + 2'd1;
    w_en = s_en[w_l];
    w_id = s_id[w_l];
    w_x  = s_x[w_l];
    w_y  = s_y[w_l];
    w_px = r_px;
    w_py = r_py;
    if (r_state == S_IDLE) begin
      w_en = r_en[w_l];
      w_id = r_id[w_l];
      w_x  = r_x[w_l];
      w_y  = r_y[w_l];
      w_px = px;
      w_py = py;
    end
  end

  assign w_hit = w_en
    && ({1'b0, w_px} >= {1'b0, w_x})
    && ({1'b0, w_px} < {1'b0, w_x} + 11'(SPRITE_W))
    && ({1'b0, w_py} >= {1'b0, w_y})
    && ({1'b0, w_py} < {1'b0, w_y} + 11'(SPRITE_H));

  assign w_dx = w_px - w_x;
  assign w_dy = w_py - w_y;
  assign w_addr = ADDR_W'(w_id) * ADDR_W'(SPRITE_W * SPRITE_H)
                + ADDR_W'(w_dy) * ADDR_W'(SPRITE_W)
                + ADDR_W'(w_dx);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_en    <= '0;
      r_id    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      s_en    <= '0;
      s_id    <= '0;
      s_x     <= '0;
      s_y     <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_ehit  <= 1'b0;
      r_eid   <= '0;
      r_valid <= 1'b0;
      r_layer <= '0;
      r_sid   <= '0;
      r_data  <= '0;
      r_bhit  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_bhit  <= 1'b0;
      // freeze a hit texel once its beat cycle ends
      if (r_bhit) r_data <= mem_data;
      if (cfg_we) begin
        r_en[cfg_layer] <= cfg_en;
        r_id[cfg_layer] <= cfg_id;
        r_x[cfg_layer]  <= cfg_x;
        r_y[cfg_layer]  <= cfg_y;
      end
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (req_valid && r_ready) begin
            s_en    <= r_en;
            s_id    <= r_id;
            s_x     <= r_x;
            s_y     <= r_y;
            r_px    <= px;
            r_py    <= py;
            r_ready <= 1'b0;
            r_k     <= 2'd0;
            r_addr  <= w_hit ? w_addr : '0;
            r_ehit  <= w_hit;
            r_eid   <= w_id;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_valid <= 1'b1;
          r_layer <= r_k;
          r_sid   <= r_ehit ? r_eid : 5'd0;
          r_bhit  <= r_ehit;
          if (!r_ehit) r_data <= TRANSPARENT;
          if (r_k == 2'd3) begin
            r_done  <= 1'b1;
            r_state <= S_LAST;
          end else begin
            r_k    <= r_k + 2'd1;
            r_addr <= w_hit ? w_addr : '0;
            r_ehit <= w_hit;
            r_eid  <= w_id;
          end
        end
        S_LAST: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign mem_addr     = r_addr;
  assign out_valid    = r_valid;
  assign sprite_layer = {3'b000, r_layer};
  assign sprite_id    = r_sid;
  assign data         = r_bhit ? mem_data : r_data;
  assign pixel_done   = r_done;

endmodule
